// File: rtl/pc_trace_buffer.sv
// Trace FIFO of fetched PC/instruction pairs with stall filtering. Entries appear on rd_* one
// cycle after capture. Capture never stalls the pipeline: if the FIFO is full, entries are dropped and counted.
module pc_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DCW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc_in,
  input  logic [31:0]     instr_in,
  input  logic            capture_en,
  input  logic            clr,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [31:0]     rd_pc,
  output logic [31:0]     rd_instr,
  output logic [AW:0]     count,
  output logic            overflow,
  output logic [DCW-1:0]  drop_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            ovf;
  logic [DCW-1:0]  drops;
  logic            have_last;
  logic [31:0]     last_pc;

  logic cand;
  logic pop;
  logic push;
  logic drop;

  // A repeated PC means the fetch stage stalled, so that sample is not a new fetch.
  assign cand     = capture_en & (~have_last | (pc_in != last_pc));
  assign rd_valid = (cnt != '0);
  assign pop      = rd_valid & rd_ready;
  assign push     = cand & ((cnt < DEPTH_V) | pop);
  assign drop     = cand & ~push;

  assign rd_pc    = rd_valid ? mem[rd_ptr].pc    : '0;
  assign rd_instr = rd_valid ? mem[rd_ptr].instr : '0;
  assign count    = cnt;
  assign overflow = ovf;
  assign drop_cnt = drops;

  // Storage carries no reset; rd_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= '{pc: pc_in, instr: instr_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      drops     <= '0;
      have_last <= 1'b0;
      last_pc   <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      drops     <= '0;
      have_last <= 1'b0;
      last_pc   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drops != '1) drops <= drops + 1'b1;
      end
      if (capture_en) begin
        last_pc   <= pc_in;
        have_last <= 1'b1;
      end else begin
        have_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer: stall filter, overflow, full+pop, wrap, re-enable and clear.
module tb_pc_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        capture_en;
  logic        clr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_trace_buffer #(.DEPTH(16), .AW(4), .DCW(16)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
    .capture_en(capture_en), .clr(clr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pc(input logic [31:0] pc);
    pc_in    = pc;
    instr_in = instr_of(pc);
  endtask

  task automatic test_reset();
    rst = 1'b0; capture_en = 1'b0; clr = 1'b0; rd_ready = 1'b0; drive_pc(32'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf got %0b/%0d exp 0/0", overflow, drop_cnt); end
    checks++; if (rd_pc !== 32'h0 || rd_instr !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h/%h exp 0/0", rd_pc, rd_instr); end
    capture_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_pc(32'h100 + 32'(4*i));
      tick();
    end
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL pre_reset_count got %0d exp 3", count); end
    drive_pc(32'h10C);
    #2 rst = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL async_reset got valid=%0b count=%0d exp 0/0", rd_valid, count); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_ovf got %0b/%0d exp 0/0", overflow, drop_cnt); end
    capture_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL post_reset_count got %0d exp 0", count); end
  endtask

  task automatic test_stall_filter();
    logic [31:0] pcs [5];
    logic [31:0] exp_pc [3];
    pcs = '{32'h00, 32'h04, 32'h04, 32'h04, 32'h08};
    exp_pc = '{32'h00, 32'h04, 32'h08};
    capture_en = 1'b1; rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_pc(pcs[i]);
      tick();
    end
    capture_en = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL stall_count got %0d exp 3", count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_pc !== exp_pc[i] || rd_instr !== instr_of(exp_pc[i])) begin
        errors++; $display("FAIL stall_read%0d got v=%0b pc=%h instr=%h exp pc=%h instr=%h",
                           i, rd_valid, rd_pc, rd_instr, exp_pc[i], instr_of(exp_pc[i]));
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL stall_empty got v=%0b count=%0d exp 0/0", rd_valid, count); end
  endtask

  task automatic test_overflow();
    capture_en = 1'b1; rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_pc(32'h200 + 32'(4*i));
      tick();
    end
    capture_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 4", drop_cnt); end
    checks++; if (rd_pc !== 32'h200 || rd_instr !== instr_of(32'h200)) begin errors++; $display("FAIL ovf_head got %h exp 00000200", rd_pc); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp;
    capture_en = 1'b1; rd_ready = 1'b1; drive_pc(32'h300);
    tick();
    capture_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullpop_count got %0d exp 16", count); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL fullpop_drop_cnt got %0d exp 4", drop_cnt); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 32'h204 + 32'(4*i) : 32'h300;
      checks++;
      if (rd_valid !== 1'b1 || rd_pc !== exp || rd_instr !== instr_of(exp)) begin
        errors++; $display("FAIL drain%0d got v=%0b pc=%h exp pc=%h", i, rd_valid, rd_pc, exp);
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0 || overflow !== 1'b1 || drop_cnt !== 16'd4) begin
      errors++; $display("FAIL drain_end got count=%0d ovf=%0b drop=%0d exp 0/1/4", count, overflow, drop_cnt);
    end
  endtask

  task automatic test_reenable_clr();
    logic en_seq [4];
    en_seq = '{1'b1, 1'b1, 1'b0, 1'b1};
    rd_ready = 1'b0; drive_pc(32'h10);
    for (int i = 0; i < 4; i++) begin
      capture_en = en_seq[i];
      tick();
    end
    capture_en = 1'b0;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL reenable_count got %0d exp 2", count); end
    checks++; if (rd_pc !== 32'h10) begin errors++; $display("FAIL reenable_head got %h exp 00000010", rd_pc); end
    clr = 1'b1; capture_en = 1'b1; rd_ready = 1'b1; drive_pc(32'h14);
    tick();
    clr = 1'b0; capture_en = 1'b0; rd_ready = 1'b0;
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL clr_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_ovf got %0b/%0d exp 0/0", overflow, drop_cnt); end
    capture_en = 1'b1;
    tick();
    capture_en = 1'b0;
    checks++; if (count !== 5'd1 || rd_pc !== 32'h14) begin errors++; $display("FAIL post_clr_push got count=%0d pc=%h exp 1/00000014", count, rd_pc); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL post_clr_drain got %0d exp 0", count); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    capture_en = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      exp = 32'h400 + 32'(4*i);
      drive_pc(exp);
      tick();
      checks++;
      if (count !== 5'd1 || rd_pc !== exp || rd_instr !== instr_of(exp)) begin
        errors++; $display("FAIL wrap%0d got count=%0d pc=%h exp 1/%h", i, count, rd_pc, exp);
      end
    end
    capture_en = 1'b0;
    tick();
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL wrap_end got count=%0d ovf=%0b drop=%0d exp 0/0/0", count, overflow, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stall_filter();
    test_overflow();
    test_full_pop();
    test_reenable_clr();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
